// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding
// and prescale limits.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  // Prescale used whenever the requested one is odd or too small
  localparam int PRESC_DEF = 8;
  // Smallest prescale that leaves room for three sample taps plus a decision cycle
  localparam int PRESC_MIN = 6;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-tap majority sampler centred on the middle of a bit period.
// Taps are stored at P/2-1 and P/2; the third tap is the live input at
// P/2+1, where the majority is presented together with sample_done so the
// controller registers the decided bit on that edge.
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] presc,
  input  logic               rx_in,
  output logic               sampled_bit,
  output logic               sample_done
);

  logic [PRESC_W-1:0] half;
  logic               tap0;
  logic               tap1;

  assign half = presc >> 1;

  // Capture the first two taps of the majority window
  always_ff @(posedge clk) begin
    if (edge_cnt == half - PRESC_W'(1)) tap0 <= rx_in;
    if (edge_cnt == half)               tap1 <= rx_in;
  end

  assign sample_done = (edge_cnt == half + PRESC_W'(1));
  assign sampled_bit = (tap0 & tap1) | (tap0 & rx_in) | (tap1 & rx_in);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start detection, majority-vote bit
// sampling, LSB-first deserialisation, parity/stop checking and break
// detection. Frame configuration is latched when a start edge is accepted.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic               stop2,
  input  logic [PRESC_W-1:0] prescale,
  output logic [DATA_W-1:0]  p_data,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               break_det,
  output logic               busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t              state, state_nxt;
  logic [PRESC_W-1:0]  edge_cnt, edge_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [DATA_W-1:0]   p_data_nxt;
  logic                par_err_nxt, stp_err_nxt;
  logic                ok_q, ok_nxt;
  logic                brk_q, brk_nxt, brk_pulse_nxt;
  logic                cfg_ld, shift_en, par_ld;

  logic [PRESC_W-1:0]  presc_q;
  logic                par_en_q, par_typ_q, stop2_q, par_bit_q;
  logic [DATA_W-1:0]   shreg;

  logic                sampled_bit, sample_done;
  logic                edge_last, last_stop, brk_cond;

  // Odd or undersized prescale values fall back to the default
  function automatic logic [PRESC_W-1:0] legal_presc(input logic [PRESC_W-1:0] p);
    if (p[0] || (p < PRESC_W'(PRESC_MIN))) return PRESC_W'(PRESC_DEF);
    return p;
  endfunction

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk         (clk),
    .edge_cnt    (edge_cnt),
    .presc       (presc_q),
    .rx_in       (rx_in),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  assign edge_last = (edge_cnt == presc_q - PRESC_W'(1));
  assign last_stop = (bit_cnt == BIT_W'(stop2_q));
  // Break: all-zero data, zero parity bit (if present) and a zero stop bit
  assign brk_cond  = (shreg == '0) && (!par_en_q || !par_bit_q) && !sampled_bit;

  // Next-state, counter and flag logic; outputs data_valid and busy
  always_comb begin
    state_nxt     = state;
    edge_nxt      = edge_cnt;
    bit_nxt       = bit_cnt;
    p_data_nxt    = p_data;
    par_err_nxt   = par_err;
    stp_err_nxt   = stp_err;
    ok_nxt        = ok_q;
    brk_nxt       = brk_q;
    brk_pulse_nxt = 1'b0;
    cfg_ld        = 1'b0;
    shift_en      = 1'b0;
    par_ld        = 1'b0;
    data_valid    = 1'b0;
    busy          = (state != IDLE);

    if ((state != IDLE) && (state != BRK_WAIT))
      edge_nxt = edge_last ? '0 : edge_cnt + PRESC_W'(1);

    case (state)
      IDLE: begin
        // The detection cycle itself is edge 0 of the start bit
        if (!rx_in) begin
          state_nxt = START;
          edge_nxt  = PRESC_W'(1);
          cfg_ld    = 1'b1;
          ok_nxt    = 1'b0;
          brk_nxt   = 1'b0;
        end
      end
      START: begin
        if (sample_done && sampled_bit) begin
          state_nxt = IDLE;
          edge_nxt  = '0;
        end else if (edge_last) begin
          state_nxt   = DATA;
          bit_nxt     = '0;
          par_err_nxt = 1'b0;
          stp_err_nxt = 1'b0;
        end
      end
      DATA: begin
        shift_en = sample_done;
        if (edge_last) begin
          if (bit_cnt == LAST_BIT) begin
            bit_nxt   = '0;
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        par_ld = sample_done;
        if (sample_done && (sampled_bit != (^shreg ^ par_typ_q)))
          par_err_nxt = 1'b1;
        if (edge_last) state_nxt = STOP;
      end
      STOP: begin
        if (sample_done) begin
          if (last_stop && brk_cond) begin
            brk_nxt       = 1'b1;
            brk_pulse_nxt = 1'b1;
            stp_err_nxt   = 1'b1;
          end else if (!sampled_bit) begin
            stp_err_nxt = 1'b1;
          end else if (last_stop && !par_err && !stp_err) begin
            ok_nxt     = 1'b1;
            p_data_nxt = shreg;
          end
        end
        data_valid = last_stop && edge_last && ok_q;
        if (edge_last) begin
          if (!last_stop) begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end else if (brk_q) begin
            state_nxt = BRK_WAIT;
            edge_nxt  = '0;
            bit_nxt   = '0;
          end else if (!rx_in) begin
            // Back-to-back frame: this cycle is the next frame's detection cycle
            state_nxt = START;
            edge_nxt  = PRESC_W'(1);
            bit_nxt   = '0;
            cfg_ld    = 1'b1;
            ok_nxt    = 1'b0;
            brk_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
            bit_nxt   = '0;
          end
        end
      end
      BRK_WAIT: begin
        // edge_cnt counts consecutive high cycles of the line
        if (rx_in) begin
          if (edge_cnt == PRESC_W'(2)) begin
            state_nxt = IDLE;
            edge_nxt  = '0;
          end else begin
            edge_nxt = edge_cnt + PRESC_W'(1);
          end
        end else begin
          edge_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        edge_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Control state, counters, status flags and the output word
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      p_data    <= '0;
      par_err   <= 1'b0;
      stp_err   <= 1'b0;
      ok_q      <= 1'b0;
      brk_q     <= 1'b0;
      break_det <= 1'b0;
    end else begin
      state     <= state_nxt;
      edge_cnt  <= edge_nxt;
      bit_cnt   <= bit_nxt;
      p_data    <= p_data_nxt;
      par_err   <= par_err_nxt;
      stp_err   <= stp_err_nxt;
      ok_q      <= ok_nxt;
      brk_q     <= brk_nxt;
      break_det <= brk_pulse_nxt;
    end
  end

  // Per-frame configuration, shift register and received parity bit
  always_ff @(posedge clk) begin
    if (cfg_ld) begin
      presc_q   <= legal_presc(prescale);
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
      stop2_q   <= stop2;
    end
    if (shift_en) shreg <= {sampled_bit, shreg[DATA_W-1:1]};
    if (par_ld)   par_bit_q <= sampled_bit;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: an 8-bit and a 5-bit instance share the
// configuration inputs; each has its own serial line. Stimulus pushes the
// expected word and pulse cycle; monitors pop and compare on each pulse.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       sel;
  logic       par_en, par_typ, stop2;
  logic [5:0] prescale;
  logic       rx8, rx5;

  logic [7:0] p_data8;
  logic       dv8, pe8, se8, bd8, busy8;
  logic [4:0] p_data5;
  logic       dv5, pe5, se5, bd5, busy5;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [8:0] d;
    int         c;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx8 = sel ? 1'b1 : rx;
  assign rx5 = sel ? rx : 1'b1;

  uart_rx_ctrl #(.DATA_W(8), .PRESC_W(6)) dut8 (
    .clk(clk), .rst(rst), .rx_in(rx8), .par_en(par_en), .par_typ(par_typ),
    .stop2(stop2), .prescale(prescale), .p_data(p_data8), .data_valid(dv8),
    .par_err(pe8), .stp_err(se8), .break_det(bd8), .busy(busy8)
  );

  uart_rx_ctrl #(.DATA_W(5), .PRESC_W(6)) dut5 (
    .clk(clk), .rst(rst), .rx_in(rx5), .par_en(par_en), .par_typ(par_typ),
    .stop2(stop2), .prescale(prescale), .p_data(p_data5), .data_valid(dv5),
    .par_err(pe5), .stp_err(se5), .break_det(bd5), .busy(busy5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: pulse seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int p);
    rx = b;
    step(p);
  endtask

  // Start bit, nb data bits LSB first, optional parity bit, stop 1 then optional stop 2.
  // chg != 0 changes the prescale input right after the start bit.
  task automatic send_frame(input logic [8:0] d, input int nb, input int p, input logic hp,
                            input logic pb, input int ns, input logic s2v, input int chg);
    send_bit(1'b0, p);
    if (chg != 0) prescale = chg[5:0];
    for (int i = 0; i < nb; i++) send_bit(d[i], p);
    if (hp) send_bit(pb, p);
    send_bit(1'b1, p);
    if (ns == 2) send_bit(s2v, p);
  endtask

  // Monitor: every pulse on either instance is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   b;
    if (dv8) begin
      if (q8.size() == 0) unexpected("dv8_unexpected");
      else begin
        e = q8.pop_front();
        chk("dv8_data", {24'd0, p_data8}, {23'd0, e.d});
        chk("dv8_cycle", cyc, e.c);
        chk("dv8_err_clear", {30'd0, pe8, se8}, 32'd0);
      end
    end
    if (dv5) begin
      if (q5.size() == 0) unexpected("dv5_unexpected");
      else begin
        e = q5.pop_front();
        chk("dv5_data", {27'd0, p_data5}, {23'd0, e.d});
        chk("dv5_cycle", cyc, e.c);
        chk("dv5_err_clear", {30'd0, pe5, se5}, 32'd0);
      end
    end
    if (bd8) begin
      if (qb.size() == 0) unexpected("brk8_unexpected");
      else begin
        b = qb.pop_front();
        chk("brk8_cycle", cyc, b);
      end
    end
    if (bd5) unexpected("brk5_unexpected");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b0; rx = 1'b1; sel = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd8;
    step(3);
    rst = 1'b1;

    // Reset state
    chk("rst_flags8", {27'd0, dv8, pe8, se8, bd8, busy8}, 32'd0);
    chk("rst_pdata8", {24'd0, p_data8}, 32'd0);
    chk("rst_flags5", {27'd0, dv5, pe5, se5, bd5, busy5}, 32'd0);
    chk("rst_pdata5", {27'd0, p_data5}, 32'd0);
    step(2);

    // 0xA5, P=8, no parity, 1 stop: pulse 10*8-1 = 79 cycles after detection
    t0 = cyc;
    q8.push_back('{9'h0A5, t0 + 79});
    send_frame(9'h0A5, 8, 8, 1'b0, 1'b0, 1, 1'b1, 0);
    chk("t1_busy_after", {31'd0, busy8}, 32'd0);
    step(3);
    chk("t1_flags", {30'd0, pe8, se8}, 32'd0);

    // Odd parity, 0x3C has four ones so parity bit must be 1; send 0
    par_en = 1'b1; par_typ = 1'b1;
    send_frame(9'h03C, 8, 8, 1'b1, 1'b0, 1, 1'b1, 0);
    step(2);
    chk("t2_par_err_set", {31'd0, pe8}, 32'd1);
    chk("t2_stp_err", {31'd0, se8}, 32'd0);
    chk("t2_pdata_held", {24'd0, p_data8}, 32'h0A5);
    t0 = cyc;
    q8.push_back('{9'h03C, t0 + 87});
    send_frame(9'h03C, 8, 8, 1'b1, 1'b1, 1, 1'b1, 0);
    step(2);
    chk("t2_par_err_clr", {31'd0, pe8}, 32'd0);

    // Two stop bits, second one 0, then 0x55 with no gap. The zero stop bit
    // starts the next frame one cycle before its bench-side start bit.
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1;
    send_frame(9'h081, 8, 8, 1'b0, 1'b0, 2, 1'b0, 0);
    chk("t3_stp_err_set", {31'd0, se8}, 32'd1);
    chk("t3_busy_restart", {31'd0, busy8}, 32'd1);
    chk("t3_pdata_held", {24'd0, p_data8}, 32'h03C);
    t0 = cyc;
    q8.push_back('{9'h055, t0 + 86});
    send_frame(9'h055, 8, 8, 1'b0, 1'b0, 2, 1'b1, 0);
    step(2);
    chk("t3_stp_err_clr", {31'd0, se8}, 32'd0);

    // Two-cycle glitch at P=16: abort decided at edge 9, idle from detection+10
    stop2 = 1'b0; prescale = 6'd16;
    rx = 1'b0;
    step(2);
    rx = 1'b1;
    chk("t4_busy_start", {31'd0, busy8}, 32'd1);
    step(10);
    chk("t4_busy_idle", {31'd0, busy8}, 32'd0);
    chk("t4_flags", {30'd0, pe8, se8}, 32'd0);
    chk("t4_pdata", {24'd0, p_data8}, 32'h055);

    // Break: line low for 20 bit times at P=8. Stop sample at detection+77,
    // pulse at +78; line high from +160, idle from +163.
    prescale = 6'd8;
    t0 = cyc;
    qb.push_back(t0 + 78);
    rx = 1'b0;
    step(160);
    rx = 1'b1;
    chk("t5_busy_wait", {31'd0, busy8}, 32'd1);
    chk("t5_stp_err", {31'd0, se8}, 32'd1);
    step(2);
    chk("t5_busy_2high", {31'd0, busy8}, 32'd1);
    step(1);
    chk("t5_busy_idle", {31'd0, busy8}, 32'd0);
    chk("t5_pdata_held", {24'd0, p_data8}, 32'h055);

    // 5-bit instance, P=6: 0x01 then 0xFF (0x1F) back to back, pulses 42 apart;
    // prescale changed to 12 during the second frame applies to the third only
    sel = 1'b1; prescale = 6'd6;
    t0 = cyc;
    q5.push_back('{9'h001, t0 + 41});
    q5.push_back('{9'h01F, t0 + 83});
    send_frame(9'h001, 5, 6, 1'b0, 1'b0, 1, 1'b1, 0);
    send_frame(9'h0FF, 5, 6, 1'b0, 1'b0, 1, 1'b1, 12);
    step(4);
    chk("t6_pdata", {27'd0, p_data5}, 32'h01F);
    t0 = cyc;
    q5.push_back('{9'h00A, t0 + 83});
    send_frame(9'h00A, 5, 12, 1'b0, 1'b0, 1, 1'b1, 0);
    step(2);
    chk("t6_busy_idle", {31'd0, busy5}, 32'd0);

    // Illegal prescale (below minimum, then odd) falls back to 8
    sel = 1'b0; prescale = 6'd5;
    t0 = cyc;
    q8.push_back('{9'h0C3, t0 + 79});
    send_frame(9'h0C3, 8, 8, 1'b0, 1'b0, 1, 1'b1, 0);
    step(2);
    chk("t7_stp_err_clr", {31'd0, se8}, 32'd0);
    prescale = 6'd9;
    t0 = cyc;
    q8.push_back('{9'h03E, t0 + 79});
    send_frame(9'h03E, 8, 8, 1'b0, 1'b0, 1, 1'b1, 0);
    step(2);

    // Reset in the middle of a frame discards it
    prescale = 6'd8;
    rx = 1'b0;
    step(12);
    chk("t8_busy_mid", {31'd0, busy8}, 32'd1);
    rst = 1'b0; rx = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    chk("t8_busy_reset", {31'd0, busy8}, 32'd0);
    chk("t8_pdata8_reset", {24'd0, p_data8}, 32'd0);
    chk("t8_pdata5_reset", {27'd0, p_data5}, 32'd0);
    step(100);

    chk("q8_drained", q8.size(), 32'd0);
    chk("q5_drained", q5.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
